// File: rtl/obstacle_layer_if.sv
// Pixel-request / pixel-response bundle between the scan counters and obstacle_layer.
interface obstacle_layer_if #(
    parameter int CIDXW = 3
);
    logic [9:0]     hCount;
    logic [9:0]     vCount;
    logic           halt;
    logic [2:0]     speed;
    logic           drawing;
    logic [CIDXW:0] pix;
    logic [2:0]     obst_count;

    modport master (
        output hCount, vCount, halt, speed,
        input  drawing, pix, obst_count
    );

    modport slave (
        input  hCount, vCount, halt, speed,
        output drawing, pix, obst_count
    );
endinterface

// File: rtl/obstacle_layer.sv
// Scrolling obstacle field plus ground line; four slots, LFSR-driven spawns, registered pixel lookup.
// Optional feature macro: OBST_BIRD_EN (type 2 spawns and draws as a bird; otherwise it becomes a cactus).
module obstacle_layer #(
    parameter int         CIDXW    = 3,
    parameter logic [9:0] GROUND_Y = 10'd400,
    parameter logic [5:0] MIN_GAP  = 6'd40
) (
    input logic             clk,
    input logic             reset,
    obstacle_layer_if.slave bus
);
    localparam int         PW         = CIDXW + 1;
    localparam logic [9:0] SPAWN_X    = 10'd784;
    localparam logic [9:0] EXIT_X     = 10'd112;
    localparam logic [CIDXW:0] PIX_CACTUS = PW'(4'b0010);
    localparam logic [CIDXW:0] PIX_ROCK   = PW'(4'b0100);
    localparam logic [CIDXW:0] PIX_TEXT   = PW'(4'b1000);
`ifdef OBST_BIRD_EN
    localparam logic [CIDXW:0] PIX_BIRD   = PW'(4'b0110);
`endif

    logic [3:0]     valid;
    logic [9:0]     xpos [4];
    logic [1:0]     otype [4];
    logic [6:0]     gap_cnt;
    logic [15:0]    lfsr;
    logic           prev_origin;
    logic           draw_q;
    logic [CIDXW:0] pix_q;
    logic [2:0]     count_q;

    logic           at_origin;
    logic           fadv;
    logic           visible;
    logic           ground;
    logic           hit;
    logic [CIDXW:0] hit_pix;
    logic           have_free;
    logic [1:0]     free_idx;
    logic [1:0]     spawn_type;
    logic [9:0]     speed_ext;
    logic [2:0]     count_next;

    function automatic logic covers(input logic [9:0] x, input logic [1:0] t,
                                    input logic [9:0] h, input logic [9:0] v);
        logic [10:0] right;
        logic [9:0]  top;
        logic [9:0]  bot;
        logic        known;
        known = 1'b1;
        right = {1'b0, x} + 11'd16;
        top   = GROUND_Y - 10'd40;
        bot   = GROUND_Y;
        case (t)
            2'd1: known = 1'b1;
`ifdef OBST_BIRD_EN
            2'd2: begin
                right = {1'b0, x} + 11'd24;
                top   = GROUND_Y - 10'd64;
                bot   = GROUND_Y - 10'd48;
            end
`endif
            2'd3: begin
                right = {1'b0, x} + 11'd24;
                top   = GROUND_Y - 10'd24;
            end
            default: known = 1'b0;
        endcase
        return known && (h >= x) && ({1'b0, h} < right) && (v > top) && (v <= bot);
    endfunction

    function automatic logic [CIDXW:0] palette(input logic [1:0] t);
        case (t)
            2'd1:    return PIX_CACTUS;
`ifdef OBST_BIRD_EN
            2'd2:    return PIX_BIRD;
`endif
            2'd3:    return PIX_ROCK;
            default: return '0;
        endcase
    endfunction

    // The origin pair is held for several clocks, so only its first cycle may advance the frame.
    assign at_origin = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
    assign fadv      = at_origin && !prev_origin && !bus.halt;
    assign visible   = (bus.hCount >= 10'd144) && (bus.hCount <= 10'd783) &&
                       (bus.vCount >= 10'd35)  && (bus.vCount <= 10'd514);
    assign ground    = (bus.vCount == GROUND_Y + 10'd1);
    assign speed_ext = {7'd0, bus.speed};
    assign count_next = {2'd0, valid[0]} + {2'd0, valid[1]} + {2'd0, valid[2]} + {2'd0, valid[3]};

`ifdef OBST_BIRD_EN
    assign spawn_type = lfsr[15:14];
`else
    assign spawn_type = (lfsr[15:14] == 2'd2) ? 2'd1 : lfsr[15:14];
`endif

    always_comb begin
        hit     = 1'b0;
        hit_pix = '0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && valid[i] && covers(xpos[i], otype[i], bus.hCount, bus.vCount)) begin
                hit     = 1'b1;
                hit_pix = palette(otype[i]);
            end
        end
    end

    // Free-slot search looks at the pre-scroll valid bits, so a slot emptied this frame waits a frame.
    always_comb begin
        have_free = 1'b0;
        free_idx  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!valid[i]) begin
                have_free = 1'b1;
                free_idx  = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid       <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                xpos[i]  <= 10'd0;
                otype[i] <= 2'd0;
            end
            gap_cnt     <= {1'b0, MIN_GAP};
            lfsr        <= 16'hACE1;
            prev_origin <= 1'b1;
            draw_q      <= 1'b0;
            pix_q       <= '0;
            count_q     <= 3'd0;
        end else begin
            prev_origin <= at_origin;
            count_q     <= count_next;
            if (visible && hit) begin
                draw_q <= 1'b1;
                pix_q  <= hit_pix;
            end else if (visible && ground) begin
                draw_q <= 1'b1;
                pix_q  <= PIX_TEXT;
            end else begin
                draw_q <= 1'b0;
                pix_q  <= '0;
            end
            if (fadv) begin
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                for (int i = 0; i < 4; i++) begin
                    if (valid[i]) begin
                        if (xpos[i] < EXIT_X + speed_ext) begin
                            valid[i] <= 1'b0;
                        end else begin
                            xpos[i] <= xpos[i] - speed_ext;
                        end
                    end
                end
                if (gap_cnt == 7'd0) begin
                    gap_cnt <= {1'b0, MIN_GAP} + {1'b0, lfsr[5:0]};
                    if ((lfsr[15:14] != 2'd0) && have_free) begin
                        valid[free_idx] <= 1'b1;
                        xpos[free_idx]  <= SPAWN_X;
                        otype[free_idx] <= spawn_type;
                    end
                end else begin
                    gap_cnt <= gap_cnt - 7'd1;
                end
            end
        end
    end

    assign bus.drawing    = draw_q;
    assign bus.pix        = pix_q;
    assign bus.obst_count = count_q;
endmodule

// File: doc/obstacle_layer.md
# obstacle_layer

Upstream pixel-source stage for `vga_bitchange`: owns the scrolling obstacle field and ground line, and produces the `drawing` / `pix` palette-index pair that the bit-change stage maps to RGB. It keeps up to four obstacle slots, spawns new obstacles pseudo-randomly at the right screen edge, and scrolls them left once per frame. Per-pixel lookup is registered, so it lags `hCount`/`vCount` by one `clk` cycle.

## Interface
- `CIDXW`, 3: palette index MSB; `pix` is `CIDXW+1` bits wide. Must be ≥3.
- `GROUND_Y`, 10'd400: ground-line row and the bottom edge of ground obstacles.
- `MIN_GAP`, 6'd40: minimum number of frames between spawns.

- `clk`  in  1: system clock (100 MHz; `hCount`/`vCount` hold for several cycles each).
- `reset`  in  1: synchronous, active-high.
- `hCount`  in  10: current horizontal pixel counter. Visible range 144..783.
- `vCount`  in  10: current vertical line counter. Visible range 35..514.
- `halt`  in  1: freezes scroll and spawn while high; pixel output continues.
- `speed`  in  3: pixels scrolled per frame; 0 means stationary.
- `drawing`  out  1: the current pixel belongs to this layer.
- `pix`  out  CIDXW+1: palette index. 4'b0010 = orange, 4'b0100 = P3, 4'b0110 = B2, 4'b1000 = text/black.
- `obst_count`  out  3: number of valid slots, 0..4.

## Operation
- **Slots 0..3.** Each slot holds `valid`, `xpos[9:0]` (left edge, in `hCount` coordinates) and `type[1:0]`.
- **Obstacle types:**
  - 1 = cactus: 16w×40h, bottom at `GROUND_Y`, pix 4'b0010.
  - 2 = bird: 24w×16h, bottom at `GROUND_Y`-48, pix 4'b0110.
  - 3 = rock: 24w×24h, bottom at `GROUND_Y`, pix 4'b0100.
  - Coverage uses `xpos ≤ hCount < xpos+w` and `bottom-h < vCount ≤ bottom`.
- **Frame advance (`fadv`).** One-cycle pulse on the first `clk` where `hCount==0 && vCount==0` and the previous cycle was not. The pair holds for multiple cycles, so `fadv` must not repeat. Suppressed while `halt`=1.
- **On `fadv`, scroll:** for each valid slot:
  - if `xpos < 112 + speed`, clear `valid`;
  - else `xpos <= xpos - speed`.
  - Arithmetic is 10-bit unsigned and never underflows by construction.
- **On `fadv`, spawn:**
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset 16'hACE1) steps once per `fadv`.
  - The countdown `gap_cnt[6:0]` decrements each `fadv`.
  - At 0, the block reloads `gap_cnt = MIN_GAP + lfsr[5:0]`.
  - If `lfsr[15:14] != 0` and a slot was free *before* this `fadv`, the lowest such slot gets `valid=1`, `xpos=784`, `type=lfsr[15:14]`.
  - `lfsr[15:14]==0` means no spawn this time; the countdown still reloads.
  - A slot freed on the same `fadv` is not reusable until the next `fadv`.
  - All four slots full means the spawn is dropped and the countdown still reloads.
- **Pixel lookup.**
  - Outside the visible area, or with no coverage: `drawing=0`, `pix=0`.
  - Obstacle coverage: priority goes to the lowest valid slot index.
  - Otherwise, if `vCount==GROUND_Y+1`: ground line, `drawing=1`, `pix=4'b1000`.
  - Obstacles override the ground line.
- **Count.** `obst_count` is the popcount of `valid`, registered.

## Timing
- **Reset values:** `drawing`=0, `pix`=0, `obst_count`=0, all slots invalid, `gap_cnt=MIN_GAP`, LFSR=16'hACE1, frame-edge detector primed so that reset asserted while at (0,0) gives no `fadv` until (0,0) is re-entered.
- **Latency:** `drawing`/`pix` reflect the `hCount`/`vCount` sampled at edge N, output after edge N+1. `obst_count` updates one cycle after the slot change.
- **Slot update timing:** slot updates occur only on the `fadv` cycle. Pixel lookup in that same cycle uses pre-update slot values.
- **`reset` mid-frame:** all slots clear next edge; output goes to ground line only from the following cycle.
- **`halt` rising mid-`fadv`-cycle:** `halt` is sampled on the same edge, so that `fadv` is suppressed.

## Configuration
- `OBST_BIRD_EN` defined: type 2 spawns as a bird.
- `OBST_BIRD_EN` undefined: an LFSR draw of 2 spawns a cactus (type 1), and bird coverage logic is not compiled.

## Test plan
- Reset, run 3 frames with `speed=2` and `halt=0` → `obst_count`=0, and `pix=4'b1000` appears only on row 401 with h in 144..783.
- Force a spawn (LFSR preload 16'h4000 and `gap_cnt`=0 via reset plus `MIN_GAP`=0 build) → slot 0 has `xpos=784`, type 1. After 10 frames at `speed=3` → `xpos=754`, and pixel (754,380) gives `pix=4'b0010` one cycle after the counters present it.
- Hold `hCount=0, vCount=0` for 4 cycles → exactly one `fadv`, so `xpos` drops by `speed` once.
- Slot at `xpos=114` with `speed=3` → freed on the next `fadv`, `obst_count` decrements. A spawn on that same `fadv` goes to the next free slot, not the freed one.
- Fill 4 slots, then reach countdown 0 → no change, `obst_count` stays 4, `gap_cnt` reloads.
- `halt=1` for 5 frames → slot `xpos` values and `gap_cnt` are unchanged, and the pixel output still shows obstacles.
